// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mmio_uart_pkg;

  // Register offsets from the window base (word-aligned only)
  localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFF = 32'h0000_0004;
  localparam logic [31:0] CTRL_OFF   = 32'h0000_0008;

  // STATUS register layout
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 4;

  // CTRL register layout
  localparam int CTRL_EN = 0;

  // Serializer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head-of-queue read data.
// Latency: pushed entry visible on pop_dat the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
// Ports: clk/reset (async active-high), push/push_dat, pop/pop_dat, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == NW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, a same-edge pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter fed by core stores through a small FIFO.
// Latency: tx falls one edge after a TXDATA store when idle, enabled and empty.
// Backpressure: none to the core; stores to a full FIFO are dropped and flag overflow.
// Ports: clk, reset (async active-high), memwrite/dataadr/writedata (core store port),
//        hit/rdata (combinational read-back), tx (serial out, idle high), busy.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  // Address decode and register access
  logic sel_txdata, sel_status, sel_ctrl;
  logic wr_txdata, wr_status, wr_ctrl;
  logic enable, overflow;

  assign sel_txdata = (dataadr == BASE_ADDR + TXDATA_OFF);
  assign sel_status = (dataadr == BASE_ADDR + STATUS_OFF);
  assign sel_ctrl   = (dataadr == BASE_ADDR + CTRL_OFF);
  assign hit        = sel_txdata | sel_status | sel_ctrl;

  assign wr_txdata = memwrite & sel_txdata;
  assign wr_status = memwrite & sel_status;
  assign wr_ctrl   = memwrite & sel_ctrl;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata[31:8]};

  // FIFO
  logic          fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dat;
  logic [NW-1:0] fifo_count;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_txdata),
    .push_dat (writedata[7:0]),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      enable   <= 1'b0;
    end else begin
      if (wr_txdata && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (wr_status && writedata[ST_OVF])  overflow <= 1'b0;
      if (wr_ctrl) enable <= writedata[CTRL_EN];
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_status) begin
      rdata[ST_FULL]                  = fifo_full;
      rdata[ST_EMPTY]                 = fifo_empty;
      rdata[ST_BUSY]                  = busy;
      rdata[ST_OVF]                   = overflow;
      rdata[ST_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(fifo_count);
    end else if (sel_ctrl) begin
      rdata[CTRL_EN] = enable;
    end
  end

  // Serializer
  uart_state_t   state, state_nxt;
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tx_nxt, busy_nxt;
  logic          bit_end;

  assign bit_end = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    tx_nxt      = tx;
    busy_nxt    = busy;
    fifo_pop    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          fifo_pop    = 1'b1;
          shreg_nxt   = fifo_dat;
          state_nxt   = S_START;
          bit_cnt_nxt = '0;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
          bit_idx_nxt = '0;
          tx_nxt      = shreg[0];
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end else begin
            // shreg[0] is the bit on the line now; shreg[1] goes out next.
            bit_idx_nxt = bit_idx + 3'd1;
            shreg_nxt   = {1'b0, shreg[7:1]};
            tx_nxt      = shreg[1];
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_nxt = '0;
          if (enable && !fifo_empty) begin
            // Chain straight into the next start bit, no idle gap.
            fifo_pop  = 1'b1;
            shreg_nxt = fifo_dat;
            state_nxt = S_START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'd4;
  localparam logic [31:0] A_CT  = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = A_ST;
  logic [31:0] writedata = '0;
  logic        hit;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  always #5 clk = ~clk;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .hit       (hit),
    .rdata     (rdata),
    .tx        (tx),
    .busy      (busy)
  );

  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue for the FIFO and a queue of per-cycle
  // line levels for the frame currently on the wire.
  logic [7:0] mq[$];
  logic       wave[$];
  logic       m_en   = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       m_tx   = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_pop, m_take, m_lvl;
  logic [7:0] m_b;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      wave.delete();
      m_en = 1'b0; m_ovf = 1'b0; m_tx = 1'b1; m_busy = 1'b0;
    end else begin
      m_pop  = (wave.size() == 0) && m_en && (mq.size() > 0);
      m_take = (mq.size() < DEPTH) || m_pop;
      if (wave.size() > 0) begin
        m_tx = wave.pop_front();
      end else if (m_pop) begin
        m_b = mq.pop_front();
        for (int i = 0; i < 10; i++) begin
          m_lvl = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : m_b[i-1];
          repeat (CPB) wave.push_back(m_lvl);
        end
        m_tx   = wave.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
      if (memwrite) begin
        if (dataadr == A_TX) begin
          if (m_take) mq.push_back(writedata[7:0]);
          else        m_ovf = 1'b1;
        end else if (dataadr == A_ST) begin
          if (writedata[3]) m_ovf = 1'b0;
        end else if (dataadr == A_CT) begin
          m_en = writedata[0];
        end
      end
    end
  end

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a == A_ST)
      r = 32'(mq.size()) * 16 + {28'b0, m_ovf, m_busy, mq.size() == 0, mq.size() == DEPTH};
    else if (a == A_CT)
      r = {31'b0, m_en};
    return r;
  endfunction

  // Continuous comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("tx", {31'b0, tx}, {31'b0, m_tx});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("hit", {31'b0, hit},
        {31'b0, (dataadr == A_TX) || (dataadr == A_ST) || (dataadr == A_CT)});
    chk("rdata", rdata, m_rdata(dataadr));
  end

  // Independent line receiver: samples each bit at its centre.
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  logic       rx_ab;

  initial forever begin
    @(negedge clk);
    if (!reset && tx === 1'b0) begin
      rx_ab = 1'b0;
      rx_b  = '0;
      for (int n = 1; n <= 38; n++) begin
        @(negedge clk);
        if (reset) rx_ab = 1'b1;
        if (n >= 6 && n < 38 && (n % 4) == 2) rx_b[3'(n / 4 - 1)] = tx;
      end
      if (!rx_ab && tx === 1'b1) rx_q.push_back(rx_b);
    end
  end

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    memwrite  = w;
    dataadr   = a;
    writedata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, A_ST, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    drive(1'b0, a, 32'h0);
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic rx_expect(input logic [7:0] b);
    chk("rx_present", {31'b0, rx_q.size() > 0}, 32'd1);
    if (rx_q.size() > 0) chk("rx_byte", {24'b0, rx_q.pop_front()}, {24'b0, b});
  endtask

  logic [9:0] frm;

  initial begin
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("reset_tx", {31'b0, tx}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    rd(A_ST, 32'h2, "reset_status");
    chk("hit_status", {31'b0, hit}, 32'd1);
    rd(BASE + 32'd6, 32'h0, "unaligned_rdata");
    chk("hit_unaligned", {31'b0, hit}, 32'd0);
    rd(A_CT, 32'h0, "reset_ctrl");

    // Single byte 0xA5: line levels start bit, LSB first, stop bit
    drive(1'b1, A_CT, 32'h1);
    drive(1'b1, A_TX, 32'h0000_12A5);
    drive(1'b0, A_ST, 32'h0);
    chk("a5_not_early", {31'b0, tx}, 32'd1);
    frm = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      idle(2);
      chk("a5_frame_bit", {31'b0, tx}, {31'b0, frm[k]});
      idle(2);
    end
    chk("a5_busy_last", {31'b0, busy}, 32'd1);
    idle(1);
    chk("a5_busy_end", {31'b0, busy}, 32'd0);
    idle(2);
    rx_expect(8'hA5);

    // Back-to-back: first pop coincides with the second store, so count stays 1
    drive(1'b1, A_TX, 32'h41);
    drive(1'b1, A_TX, 32'h42);
    drive(1'b0, A_ST, 32'h0);
    #1 chk("b2b_status_a", rdata, 32'h14);
    idle(39);
    chk("b2b_stop", {31'b0, tx}, 32'd1);
    idle(1);
    chk("b2b_no_gap", {31'b0, tx}, 32'd0);
    #1 chk("b2b_status_b", rdata, 32'h06);
    idle(42);
    #1 chk("b2b_status_c", rdata, 32'h02);
    rx_expect(8'h41);
    rx_expect(8'h42);

    // Overflow with transmit disabled; upper store bits are junk
    drive(1'b1, A_CT, 32'h0);
    for (int i = 1; i <= 5; i++) drive(1'b1, A_TX, 32'hDEAD_BE00 | 32'(i * 8'h11));
    drive(1'b0, A_ST, 32'h0);
    #1 chk("ovf_status", rdata, 32'h49);
    chk("ovf_tx_idle", {31'b0, tx}, 32'd1);
    drive(1'b1, A_ST, 32'h8);
    drive(1'b0, A_ST, 32'h0);
    #1 chk("ovf_cleared", rdata, 32'h41);
    drive(1'b1, A_CT, 32'h1);
    idle(170);
    #1 chk("ovf_drained", rdata, 32'h02);
    rx_expect(8'h11);
    rx_expect(8'h22);
    rx_expect(8'h33);
    rx_expect(8'h44);

    // Full FIFO plus store on the pop edge
    drive(1'b1, A_CT, 32'h0);
    for (int i = 1; i <= 4; i++) drive(1'b1, A_TX, 32'h60 + 32'(i));
    drive(1'b0, A_ST, 32'h0);
    #1 chk("full_status", rdata, 32'h41);
    drive(1'b1, A_CT, 32'h1);
    drive(1'b1, A_TX, 32'h65);
    drive(1'b0, A_ST, 32'h0);
    #1 chk("full_pop_push", rdata, 32'h45);
    idle(205);
    #1 chk("full_drained", rdata, 32'h02);
    for (int i = 1; i <= 5; i++) rx_expect(8'h60 + 8'(i));

    // Reset during data bit 3 of 0x52 (bit 3 is 0)
    drive(1'b1, A_TX, 32'h52);
    drive(1'b0, A_ST, 32'h0);
    idle(18);
    chk("mid_bit3", {31'b0, tx}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_tx", {31'b0, tx}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    rd(A_ST, 32'h2, "post_reset_status");
    rd(A_CT, 32'h0, "post_reset_ctrl");
    idle(50);
    chk("post_reset_tx", {31'b0, tx}, 32'd1);
    chk("rx_leftover", 32'(rx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
